// File: rtl/alu_operand_stage.sv
// Decode-to-execute operand register: resolves forwarding for both sources,
// picks operand B (sign-extended immediate or rt), and registers the ALU inputs.
module alu_operand_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic [15:0] immediate,
  input  logic        use_immediate,
  input  logic [1:0]  alu_op,
  input  logic        reg_write,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd_addr,
  input  logic [31:0] exmem_data,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd_addr,
  input  logic [31:0] memwb_data,
  output logic [31:0] input_data_A,
  output logic [31:0] input_data_B,
  output logic [1:0]  selector,
  output logic [4:0]  out_rd_addr,
  output logic        out_reg_write,
  output logic        out_valid
);

  // Slot semantics: in_valid marks a real instruction in decode; out_valid marks
  // a real instruction in the registered slot. There is no back-pressure
  // handshake: stall freezes the slot, flush or in_valid=0 loads a bubble.

  logic        exmem_hit_rs, memwb_hit_rs, exmem_hit_rt, memwb_hit_rt;
  logic [31:0] fwd_rs, fwd_rt, operand_b;

  // Register 0 is hardwired, so a zero address never matches a producer.
  assign exmem_hit_rs = exmem_reg_write && (exmem_rd_addr == rs_addr) && (rs_addr != 5'd0);
  assign memwb_hit_rs = memwb_reg_write && (memwb_rd_addr == rs_addr) && (rs_addr != 5'd0);
  assign exmem_hit_rt = exmem_reg_write && (exmem_rd_addr == rt_addr) && (rt_addr != 5'd0);
  assign memwb_hit_rt = memwb_reg_write && (memwb_rd_addr == rt_addr) && (rt_addr != 5'd0);

  always_comb begin
    fwd_rs = rs_data;
    if (exmem_hit_rs)      fwd_rs = exmem_data;
    else if (memwb_hit_rs) fwd_rs = memwb_data;

    fwd_rt = rt_data;
    if (exmem_hit_rt)      fwd_rt = exmem_data;
    else if (memwb_hit_rt) fwd_rt = memwb_data;

    operand_b = use_immediate ? {{16{immediate[15]}}, immediate} : fwd_rt;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush || (!stall && !in_valid)) begin
      input_data_A  <= 32'd0;
      input_data_B  <= 32'd0;
      selector      <= 2'd0;
      out_rd_addr   <= 5'd0;
      out_reg_write <= 1'b0;
      out_valid     <= 1'b0;
    end else if (!stall) begin
      input_data_A  <= fwd_rs;
      input_data_B  <= operand_b;
      selector      <= alu_op;
      out_rd_addr   <= rd_addr;
      out_reg_write <= reg_write;
      out_valid     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: a table of single-cycle vectors plus
// hand-written stall, flush and reset sequences.
module tb_alu_operand_stage;

  logic        clock, reset_n, stall, flush, in_valid;
  logic [31:0] rs_data, rt_data, exmem_data, memwb_data;
  logic [4:0]  rs_addr, rt_addr, rd_addr, exmem_rd_addr, memwb_rd_addr;
  logic [15:0] immediate;
  logic        use_immediate, reg_write, exmem_reg_write, memwb_reg_write;
  logic [1:0]  alu_op;
  logic [31:0] input_data_A, input_data_B;
  logic [1:0]  selector;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write, out_valid;

  // Packed outputs: {A, B, selector, rd, reg_write, valid}
  localparam int W = 73;

  typedef struct {
    string       name;
    logic        in_valid;
    logic [31:0] rs_data, rt_data, exmem_data, memwb_data;
    logic [4:0]  rs_addr, rt_addr, rd_addr, exmem_rd_addr, memwb_rd_addr;
    logic [15:0] immediate;
    logic        use_immediate, reg_write, exmem_reg_write, memwb_reg_write;
    logic [1:0]  alu_op;
    logic [W-1:0] exp;
  } vec_t;

  vec_t table_v[$];
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_operand_stage dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .rs_data(rs_data), .rt_data(rt_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .immediate(immediate), .use_immediate(use_immediate), .alu_op(alu_op),
    .reg_write(reg_write), .exmem_reg_write(exmem_reg_write),
    .exmem_rd_addr(exmem_rd_addr), .exmem_data(exmem_data),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr),
    .memwb_data(memwb_data), .input_data_A(input_data_A),
    .input_data_B(input_data_B), .selector(selector),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
    .out_valid(out_valid)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] pack(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] sel, input logic [4:0] rd,
                                        input logic we, input logic v);
    return {a, b, sel, rd, we, v};
  endfunction

  function automatic vec_t base_vec(input string name);
    vec_t v;
    v.name = name; v.in_valid = 1'b1;
    v.rs_data = 32'd0; v.rt_data = 32'd0; v.exmem_data = 32'd0; v.memwb_data = 32'd0;
    v.rs_addr = 5'd1; v.rt_addr = 5'd2; v.rd_addr = 5'd4;
    v.exmem_rd_addr = 5'd0; v.memwb_rd_addr = 5'd0;
    v.immediate = 16'd0; v.use_immediate = 1'b0; v.reg_write = 1'b1;
    v.exmem_reg_write = 1'b0; v.memwb_reg_write = 1'b0; v.alu_op = 2'b00;
    v.exp = '0;
    return v;
  endfunction

  // driver
  task automatic drive(input vec_t v);
    in_valid = v.in_valid; rs_data = v.rs_data; rt_data = v.rt_data;
    rs_addr = v.rs_addr; rt_addr = v.rt_addr; rd_addr = v.rd_addr;
    immediate = v.immediate; use_immediate = v.use_immediate; alu_op = v.alu_op;
    reg_write = v.reg_write; exmem_reg_write = v.exmem_reg_write;
    exmem_rd_addr = v.exmem_rd_addr; exmem_data = v.exmem_data;
    memwb_reg_write = v.memwb_reg_write; memwb_rd_addr = v.memwb_rd_addr;
    memwb_data = v.memwb_data;
  endtask

  // scoreboard: one edge, then compare the registered outputs
  task automatic step_check(input string name, input logic [W-1:0] exp);
    logic [W-1:0] act, e;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    act = {input_data_A, input_data_B, selector, out_rd_addr, out_reg_write, out_valid};
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got A=%h B=%h sel=%b rd=%0d we=%b v=%b, expected A=%h B=%h sel=%b rd=%0d we=%b v=%b",
               name, act[72:41], act[40:9], act[8:7], act[6:2], act[1], act[0],
               e[72:41], e[40:9], e[8:7], e[6:2], e[1], e[0]);
    end
  endtask

  initial begin
    vec_t v;

    v = base_vec("basic_load");
    v.rs_data = 32'd5; v.rt_data = 32'd7; v.alu_op = 2'b01;
    v.exp = pack(32'd5, 32'd7, 2'b01, 5'd4, 1'b1, 1'b1); table_v.push_back(v);

    v = base_vec("imm_negative");
    v.rs_data = 32'd10; v.rt_data = 32'd3; v.immediate = 16'hFFFC; v.use_immediate = 1'b1;
    v.exp = pack(32'd10, 32'hFFFFFFFC, 2'b00, 5'd4, 1'b1, 1'b1); table_v.push_back(v);

    v = base_vec("imm_positive");
    v.rt_data = 32'hDEAD; v.immediate = 16'h0004; v.use_immediate = 1'b1;
    v.exp = pack(32'd0, 32'h00000004, 2'b00, 5'd4, 1'b1, 1'b1); table_v.push_back(v);

    v = base_vec("fwd_exmem_wins");
    v.rs_addr = 5'd3; v.rs_data = 32'h11;
    v.exmem_reg_write = 1'b1; v.exmem_rd_addr = 5'd3; v.exmem_data = 32'hAA;
    v.memwb_reg_write = 1'b1; v.memwb_rd_addr = 5'd3; v.memwb_data = 32'hBB;
    v.exp = pack(32'hAA, 32'd0, 2'b00, 5'd4, 1'b1, 1'b1); table_v.push_back(v);

    v.name = "fwd_memwb";
    v.exmem_reg_write = 1'b0;
    v.exp = pack(32'hBB, 32'd0, 2'b00, 5'd4, 1'b1, 1'b1); table_v.push_back(v);

    v = base_vec("reg_zero");
    v.rs_addr = 5'd0; v.rs_data = 32'd0;
    v.exmem_reg_write = 1'b1; v.exmem_rd_addr = 5'd0; v.exmem_data = 32'h55;
    v.exp = pack(32'd0, 32'd0, 2'b00, 5'd4, 1'b1, 1'b1); table_v.push_back(v);

    v = base_vec("reg_zero_rf_data");
    v.rs_addr = 5'd0; v.rs_data = 32'h1234; v.rt_addr = 5'd0; v.rt_data = 32'h5678;
    v.exmem_reg_write = 1'b1; v.exmem_rd_addr = 5'd0; v.exmem_data = 32'h55;
    v.memwb_reg_write = 1'b1; v.memwb_rd_addr = 5'd0; v.memwb_data = 32'h66;
    v.exp = pack(32'h1234, 32'h5678, 2'b00, 5'd4, 1'b1, 1'b1); table_v.push_back(v);

    v = base_vec("fwd_rt_memwb");
    v.rt_addr = 5'd6; v.rt_data = 32'h1; v.rs_data = 32'h2;
    v.memwb_reg_write = 1'b1; v.memwb_rd_addr = 5'd6; v.memwb_data = 32'h77;
    v.exmem_reg_write = 1'b1; v.exmem_rd_addr = 5'd9; v.exmem_data = 32'h99;
    v.exp = pack(32'h2, 32'h77, 2'b00, 5'd4, 1'b1, 1'b1); table_v.push_back(v);

    v.name = "fwd_rt_exmem_same_reg";
    v.rs_addr = 5'd6; v.exmem_rd_addr = 5'd6;
    v.exp = pack(32'h99, 32'h99, 2'b00, 5'd4, 1'b1, 1'b1); table_v.push_back(v);

    v.name = "imm_overrides_rt_fwd";
    v.use_immediate = 1'b1; v.immediate = 16'h7FFF;
    v.exp = pack(32'h99, 32'h00007FFF, 2'b00, 5'd4, 1'b1, 1'b1); table_v.push_back(v);

    v = base_vec("and_no_write");
    v.rs_data = 32'hF0F0; v.rt_data = 32'h0FF0; v.alu_op = 2'b10; v.reg_write = 1'b0; v.rd_addr = 5'd31;
    v.exp = pack(32'hF0F0, 32'h0FF0, 2'b10, 5'd31, 1'b0, 1'b1); table_v.push_back(v);

    v = base_vec("bubble_invalid");
    v.in_valid = 1'b0; v.rs_data = 32'h3; v.rt_data = 32'h4; v.alu_op = 2'b11;
    v.exp = '0; table_v.push_back(v);

    // reset state
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
    v = base_vec("reset_inputs"); v.rs_data = 32'hFF; drive(v);
    step_check("reset_state", '0);
    reset_n = 1'b1;

    // first edge after reset release loads normally
    v = base_vec("first_load"); v.rs_data = 32'h21; v.alu_op = 2'b11; drive(v);
    step_check("first_load_after_reset", pack(32'h21, 32'd0, 2'b11, 5'd4, 1'b1, 1'b1));

    foreach (table_v[i]) begin
      drive(table_v[i]);
      step_check(table_v[i].name, table_v[i].exp);
    end

    // stall holds through changing data and forwarding inputs
    v = base_vec("load_nine"); v.rs_data = 32'd9; v.rt_data = 32'd2; v.alu_op = 2'b01; drive(v);
    step_check("load_nine", pack(32'd9, 32'd2, 2'b01, 5'd4, 1'b1, 1'b1));
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v = base_vec("stall_noise");
      v.rs_data = 32'($urandom_range(100, 200)); v.rt_data = 32'($urandom_range(100, 200));
      v.exmem_reg_write = 1'b1; v.exmem_rd_addr = 5'd1; v.exmem_data = 32'h4000 + 32'(k);
      v.alu_op = 2'b10; v.in_valid = k[0];
      drive(v);
      step_check("stall_hold", pack(32'd9, 32'd2, 2'b01, 5'd4, 1'b1, 1'b1));
    end
    flush = 1'b1;
    step_check("stall_and_flush", '0);
    stall = 1'b0; flush = 1'b0;

    // flush alone
    v = base_vec("reload"); v.rs_data = 32'h5A; drive(v);
    step_check("reload", pack(32'h5A, 32'd0, 2'b00, 5'd4, 1'b1, 1'b1));
    flush = 1'b1;
    step_check("flush_only", '0);
    flush = 1'b0;

    // reset during a stall clears held contents, then next edge loads
    v = base_vec("pre_reset"); v.rs_data = 32'd9; v.rt_data = 32'd8; drive(v);
    step_check("pre_reset_load", pack(32'd9, 32'd8, 2'b00, 5'd4, 1'b1, 1'b1));
    stall = 1'b1;
    step_check("stall_before_reset", pack(32'd9, 32'd8, 2'b00, 5'd4, 1'b1, 1'b1));
    reset_n = 1'b0;
    step_check("reset_mid_stall", '0);
    reset_n = 1'b1; stall = 1'b0;
    v = base_vec("post_reset"); v.rs_data = 32'h33; v.rt_data = 32'h44; v.alu_op = 2'b01; v.rd_addr = 5'd7; drive(v);
    step_check("load_after_reset", pack(32'h33, 32'h44, 2'b01, 5'd7, 1'b1, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
